// File: rtl/hilo_pkg.sv
// Shared op-code values, FSM state encoding and unit select for the HI/LO issue stage.
package hilo_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_NOP  = 3'd0;
    localparam op_t OP_MULT = 3'd1;
    localparam op_t OP_DIV  = 3'd2;
    localparam op_t OP_MTHI = 3'd3;
    localparam op_t OP_MTLO = 3'd4;
    localparam op_t OP_MFHI = 3'd5;
    localparam op_t OP_MFLO = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        SEL_MULT = 1'b0,
        SEL_DIV  = 1'b1
    } unit_sel_e;

    function automatic logic is_arith(input op_t code);
        return (code == OP_MULT) || (code == OP_DIV);
    endfunction

endpackage

// File: rtl/hilo_if.sv
// Pipeline-side op handshake and arithmetic-unit handshake bundles.
interface hilo_op_if;
    import hilo_pkg::*;

    logic        op_valid;
    op_t         op_code;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_ready;
    logic        stall;
    logic        rd_valid;
    logic [31:0] rd_data;

    modport master (
        output op_valid, op_code, op_a, op_b,
        input  op_ready, stall, rd_valid, rd_data
    );

    modport slave (
        input  op_valid, op_code, op_a, op_b,
        output op_ready, stall, rd_valid, rd_data
    );
endinterface

interface hilo_unit_if;
    logic        mult_start;
    logic        div_start;
    logic [31:0] unit_a;
    logic [31:0] unit_b;
    logic        mult_end;
    logic [31:0] mult_hi;
    logic [31:0] mult_lo;
    logic        div_end;
    logic [31:0] div_hi;
    logic [31:0] div_lo;

    modport master (
        output mult_start, div_start, unit_a, unit_b,
        input  mult_end, mult_hi, mult_lo, div_end, div_hi, div_lo
    );

    modport slave (
        input  mult_start, div_start, unit_a, unit_b,
        output mult_end, mult_hi, mult_lo, div_end, div_hi, div_lo
    );
endinterface

// File: rtl/hilo_timer.sv
// Wait-state watchdog: counts cycles while enabled and flags the last allowed cycle.
module hilo_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired_o = (cnt_q == CNT_LAST);

    // Next count: clear wins, never wrap past the last value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO issue/writeback stage: sequences MULT/DIV through the external iterative units,
// services MT/MF moves and owns the architectural HI/LO registers.
module hilo_ctrl
    import hilo_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    hilo_op_if.slave    op_if,
    hilo_unit_if.master unit_if,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        done_o,
    output logic        timeout_err_o
);

    state_e      state_q,       state_d;
    unit_sel_e   sel_q,         sel_d;
    logic [31:0] unit_a_q,      unit_a_d;
    logic [31:0] unit_b_q,      unit_b_d;
    logic [31:0] hi_q,          hi_d;
    logic [31:0] lo_q,          lo_d;
    logic        rd_valid_q,    rd_valid_d;
    logic [31:0] rd_data_q,     rd_data_d;
    logic        done_q,        done_d;
    logic        mult_start_q,  mult_start_d;
    logic        div_start_q,   div_start_d;
    logic        timeout_err_q, timeout_err_d;

    logic        op_ready_s;
    logic        accept_s;
    logic        sel_end_s;
    logic [31:0] res_hi_s;
    logic [31:0] res_lo_s;
    logic        expired_s;

    assign op_ready_s = (state_q == S_IDLE);
    assign accept_s   = op_if.op_valid & op_ready_s;
    // Only the selected unit's end flag and results matter; the other unit may hold stale values.
    assign sel_end_s  = (sel_q == SEL_DIV) ? unit_if.div_end : unit_if.mult_end;
    assign res_hi_s   = (sel_q == SEL_DIV) ? unit_if.div_hi  : unit_if.mult_hi;
    assign res_lo_s   = (sel_q == SEL_DIV) ? unit_if.div_lo  : unit_if.mult_lo;

    hilo_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (state_q == S_ISSUE),
        .en_i      ((state_q == S_WAIT) && !sel_end_s),
        .expired_o (expired_s)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s && is_arith(op_if.op_code)) begin
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (sel_end_s) begin
                    state_d = S_DONE;
                end else if (expired_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        sel_d         = sel_q;
        unit_a_d      = unit_a_q;
        unit_b_d      = unit_b_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        rd_valid_d    = 1'b0;
        rd_data_d     = rd_data_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    case (op_if.op_code)
                        OP_MULT: begin
                            unit_a_d = op_if.op_a;
                            unit_b_d = op_if.op_b;
                            sel_d    = SEL_MULT;
                        end
                        OP_DIV: begin
                            unit_a_d = op_if.op_a;
                            unit_b_d = op_if.op_b;
                            sel_d    = SEL_DIV;
                        end
                        OP_MTHI: hi_d = op_if.op_a;
                        OP_MTLO: lo_d = op_if.op_a;
                        OP_MFHI: begin
                            rd_data_d  = hi_q;
                            rd_valid_d = 1'b1;
                        end
                        OP_MFLO: begin
                            rd_data_d  = lo_q;
                            rd_valid_d = 1'b1;
                        end
                        default: begin
                            rd_valid_d = 1'b0;
                        end
                    endcase
                end else begin
                    rd_valid_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (!sel_end_s && expired_s) begin
                    timeout_err_d = 1'b1;
                end else begin
                    timeout_err_d = timeout_err_q;
                end
            end
            S_DONE: begin
                hi_d = res_hi_s;
                lo_d = res_lo_s;
            end
            default: begin
                rd_valid_d = 1'b0;
            end
        endcase
        // Starts and done are decoded from the upcoming state so they are flops aligned with it.
        mult_start_d = (state_d == S_ISSUE) && (sel_d == SEL_MULT);
        div_start_d  = (state_d == S_ISSUE) && (sel_d == SEL_DIV);
        done_d       = (state_d == S_DONE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_q         <= SEL_MULT;
            unit_a_q      <= 32'd0;
            unit_b_q      <= 32'd0;
            hi_q          <= 32'd0;
            lo_q          <= 32'd0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= 32'd0;
            done_q        <= 1'b0;
            mult_start_q  <= 1'b0;
            div_start_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            sel_q         <= sel_d;
            unit_a_q      <= unit_a_d;
            unit_b_q      <= unit_b_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
            done_q        <= done_d;
            mult_start_q  <= mult_start_d;
            div_start_q   <= div_start_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign op_if.op_ready     = op_ready_s;
    assign op_if.stall        = op_if.op_valid & ~op_ready_s;
    assign op_if.rd_valid     = rd_valid_q;
    assign op_if.rd_data      = rd_data_q;
    assign unit_if.mult_start = mult_start_q;
    assign unit_if.div_start  = div_start_q;
    assign unit_if.unit_a     = unit_a_q;
    assign unit_if.unit_b     = unit_b_q;
    assign hi_o               = hi_q;
    assign lo_o               = lo_q;
    assign done_o             = done_q;
    assign timeout_err_o      = timeout_err_q;

endmodule
